global_ldst_req_sched: RTL

//  Scheduler between NrClusters Ara clusters and global_ldst. Collects one AR (and one AW) from every

---
 rtl/global_ldst_pkg.sv | 68 ++++++
 rtl/global_ldst_ax_barrier.sv | 120 ++++++++++++
 rtl/global_ldst_req_sched.sv | 104 ++++++++++
 3 files changed

// File: rtl/global_ldst_pkg.sv
// Shared types for the global_ldst request scheduler: AXI channel structs, barrier FSM states
// and the outstanding-counter width helper.
package global_ldst_pkg;

  localparam int unsigned IdWidth   = 4;
  localparam int unsigned AddrWidth = 32;
  localparam int unsigned DataWidth = 32;
  localparam int unsigned StrbWidth = DataWidth / 8;

  typedef enum logic [1:0] {
    StCollect,
    StWaitCredit,
    StIssue
  } barrier_state_e;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [AddrWidth-1:0] addr;
    logic [7:0]           len;
    logic [2:0]           size;
    logic [1:0]           burst;
  } ax_chan_t;

  typedef struct packed {
    logic [DataWidth-1:0] data;
    logic [StrbWidth-1:0] strb;
    logic                 last;
  } w_chan_t;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [DataWidth-1:0] data;
    logic [1:0]           resp;
    logic                 last;
  } r_chan_t;

  typedef struct packed {
    logic [IdWidth-1:0] id;
    logic [1:0]         resp;
  } b_chan_t;

  typedef struct packed {
    ax_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ax_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } axi_req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } axi_resp_t;

  // Counter must be able to hold MaxOutstanding itself.
  function automatic int unsigned cnt_width(input int unsigned max_outstanding);
    return $clog2(max_outstanding + 1);
  endfunction

endpackage

// File: rtl/global_ldst_ax_barrier.sv
// Address-channel barrier: gathers one request per cluster, then issues them together once an
// outstanding-burst credit is available.
module global_ldst_ax_barrier
  import global_ldst_pkg::*;
#(
  parameter int unsigned NrClusters     = 4,
  parameter int unsigned MaxOutstanding = 4,
  parameter type         ax_t           = ax_chan_t
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NrClusters-1:0] cl_valid,
  input  ax_t                   cl_ax [NrClusters],
  output logic [NrClusters-1:0] cl_ready,
  output logic                  ldst_valid,
  output ax_t                   ldst_ax [NrClusters],
  input  logic                  ldst_ready,
  input  logic                  dec,
  output logic                  idle,
  output logic                  mismatch,
  output logic                  underflow
);

  localparam int unsigned           CntWidth = cnt_width(MaxOutstanding);
  localparam logic [CntWidth-1:0]   MaxCnt   = CntWidth'(MaxOutstanding);
  localparam logic [CntWidth-1:0]   CntOne   = CntWidth'(1);

  barrier_state_e        state_q, state_d;
  logic [NrClusters-1:0] pend_q, pend_d;
  ax_t                   slot_q [NrClusters];
  ax_t                   slot_d [NrClusters];
  logic [CntWidth-1:0]   cnt_q, cnt_d, cnt_drained;
  logic                  inc, credit_ok, fields_differ;

  // Valid and ready depend on registered state only.
  assign cl_ready   = (state_q == StCollect) ? ~pend_q : '0;
  assign ldst_valid = (state_q == StIssue);
  assign ldst_ax    = slot_q;
  assign idle       = (pend_q == '0) && (cnt_q == '0);

  // No increment happens outside StIssue, so the drained count is the next count there.
  always_comb begin
    cnt_drained = cnt_q;
    if (dec && (cnt_q != '0)) begin
      cnt_drained = cnt_q - CntOne;
    end
    underflow = dec && (cnt_q == '0);
    credit_ok = (cnt_drained < MaxCnt);
  end

  always_comb begin
    fields_differ = 1'b0;
    for (int i = 1; i < NrClusters; i++) begin
      if ((slot_q[i].len != slot_q[0].len) || (slot_q[i].size != slot_q[0].size) ||
          (slot_q[i].burst != slot_q[0].burst) || (slot_q[i].id != slot_q[0].id)) begin
        fields_differ = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    slot_d   = slot_q;
    inc      = 1'b0;
    mismatch = 1'b0;
    unique case (state_q)
      StCollect: begin
        for (int i = 0; i < NrClusters; i++) begin
          if (cl_valid[i] && !pend_q[i]) begin
            slot_d[i] = cl_ax[i];
            pend_d[i] = 1'b1;
          end
        end
        if (&pend_d) begin
          state_d = credit_ok ? StIssue : StWaitCredit;
        end
      end
      StWaitCredit: begin
        if (credit_ok) begin
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (ldst_ready) begin
          inc      = 1'b1;
          pend_d   = '0;
          mismatch = fields_differ;
          state_d  = StCollect;
        end
      end
      default: state_d = StCollect;
    endcase
  end

  always_comb begin
    unique case ({inc, dec})
      2'b10:   cnt_d = cnt_q + CntOne;
      2'b01:   cnt_d = cnt_drained;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StCollect;
      pend_q  <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < NrClusters; i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      slot_q  <= slot_d;
    end
  end

endmodule

// File: rtl/global_ldst_req_sched.sv
// Scheduler between the Ara clusters and global_ldst: barriers the AR and AW channels and passes
// W, R and B straight through.
module global_ldst_req_sched
  import global_ldst_pkg::*;
#(
  parameter int unsigned NrClusters         = 4,
  parameter int unsigned MaxOutstanding     = 4,
  parameter type         cluster_axi_req_t  = axi_req_t,
  parameter type         cluster_axi_resp_t = axi_resp_t
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  cluster_axi_req_t  cl_req_i    [NrClusters],
  output cluster_axi_resp_t cl_resp_o   [NrClusters],
  output cluster_axi_req_t  ldst_req_o  [NrClusters],
  input  cluster_axi_resp_t ldst_resp_i [NrClusters],
  output logic              idle_o,
  output logic              mismatch_o,
  output logic              underflow_o
);

  logic [NrClusters-1:0] ar_cl_valid, ar_cl_ready, aw_cl_valid, aw_cl_ready;
  ax_chan_t              ar_cl_ax   [NrClusters];
  ax_chan_t              aw_cl_ax   [NrClusters];
  ax_chan_t              ar_ldst_ax [NrClusters];
  ax_chan_t              aw_ldst_ax [NrClusters];
  logic                  ar_ldst_valid, aw_ldst_valid;
  logic                  ar_idle, aw_idle, ar_mismatch, aw_mismatch, ar_underflow, aw_underflow;
  logic                  rd_dec, wr_dec;

  // Only cluster 0's response stream is counted; all clusters see the same bursts.
  assign rd_dec = ldst_resp_i[0].r_valid & ldst_resp_i[0].r.last & cl_req_i[0].r_ready;
  assign wr_dec = ldst_resp_i[0].b_valid & cl_req_i[0].b_ready;

  always_comb begin
    for (int i = 0; i < NrClusters; i++) begin
      ar_cl_valid[i] = cl_req_i[i].ar_valid;
      ar_cl_ax[i]    = cl_req_i[i].ar;
      aw_cl_valid[i] = cl_req_i[i].aw_valid;
      aw_cl_ax[i]    = cl_req_i[i].aw;
    end
  end

  always_comb begin
    for (int i = 0; i < NrClusters; i++) begin
      ldst_req_o[i]          = cl_req_i[i];
      ldst_req_o[i].ar_valid = ar_ldst_valid;
      ldst_req_o[i].ar       = ar_ldst_ax[i];
      ldst_req_o[i].aw_valid = aw_ldst_valid;
      ldst_req_o[i].aw       = aw_ldst_ax[i];
    end
  end

  always_comb begin
    for (int i = 0; i < NrClusters; i++) begin
      cl_resp_o[i]          = ldst_resp_i[i];
      cl_resp_o[i].ar_ready = ar_cl_ready[i];
      cl_resp_o[i].aw_ready = aw_cl_ready[i];
    end
  end

  global_ldst_ax_barrier #(
    .NrClusters     (NrClusters),
    .MaxOutstanding (MaxOutstanding),
    .ax_t           (ax_chan_t)
  ) u_ar_barrier (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .cl_valid   (ar_cl_valid),
    .cl_ax      (ar_cl_ax),
    .cl_ready   (ar_cl_ready),
    .ldst_valid (ar_ldst_valid),
    .ldst_ax    (ar_ldst_ax),
    .ldst_ready (ldst_resp_i[0].ar_ready),
    .dec        (rd_dec),
    .idle       (ar_idle),
    .mismatch   (ar_mismatch),
    .underflow  (ar_underflow)
  );

  global_ldst_ax_barrier #(
    .NrClusters     (NrClusters),
    .MaxOutstanding (MaxOutstanding),
    .ax_t           (ax_chan_t)
  ) u_aw_barrier (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .cl_valid   (aw_cl_valid),
    .cl_ax      (aw_cl_ax),
    .cl_ready   (aw_cl_ready),
    .ldst_valid (aw_ldst_valid),
    .ldst_ax    (aw_ldst_ax),
    .ldst_ready (ldst_resp_i[0].aw_ready),
    .dec        (wr_dec),
    .idle       (aw_idle),
    .mismatch   (aw_mismatch),
    .underflow  (aw_underflow)
  );

  assign idle_o      = ar_idle & aw_idle;
  assign mismatch_o  = ar_mismatch | aw_mismatch;
  assign underflow_o = ar_underflow | aw_underflow;

endmodule
